// File: rtl/uart_pkg.sv
// Shared UART constants and types: baud generator defaults and divisor type.
package uart_pkg;

    localparam int unsigned BAUD_CNT_W       = 16;
    localparam int unsigned BAUD_OSR         = 16;
    localparam int unsigned BAUD_DEFAULT_DIV = 40;

    typedef logic [BAUD_CNT_W-1:0] baud_div_t;

endpackage

// File: rtl/baud_div_cnt.sv
// Generic modulo-N counter: counts 0..i_last on i_inc and flags the wrap cycle.
module baud_div_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    input  logic [W-1:0] i_last,
    output logic         o_wrap
);

    logic [W-1:0] r_cnt;

    // Clear wins over a coincident wrap, so no wrap is reported in a clear cycle.
    assign o_wrap = i_inc & ~i_clr & (r_cnt == i_last);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || o_wrap) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/baud_gen_prog.sv
// Programmable UART baud generator: RX oversample tick and TX bit tick from one clock.
// Optional phase restart on rx_resync when BAUD_RESYNC_EN is defined.
module baud_gen_prog
    import uart_pkg::*;
#(
    parameter int unsigned CNT_W       = BAUD_CNT_W,
    parameter int unsigned OSR         = BAUD_OSR,
    parameter int unsigned DEFAULT_DIV = BAUD_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             div_wr,
    input  logic [CNT_W-1:0] div_in,
`ifdef BAUD_RESYNC_EN
    input  logic             rx_resync,
`endif
    output logic [CNT_W-1:0] div_cur,
    output logic             baud_tick_R,
    output logic             baud_tick_T
);

    localparam int unsigned      PH_W    = $clog2(OSR);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(OSR - 1);
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] r_shadow;
    logic [CNT_W-1:0] r_div_cur;
    logic             r_tick_R;
    logic             r_tick_T;

    logic             w_resync;
    logic             w_clr;
    logic [CNT_W-1:0] w_eff_last;
    logic             w_os_wrap;
    logic             w_ph_wrap;

`ifdef BAUD_RESYNC_EN
    assign w_resync = en & rx_resync;
`else
    assign w_resync = 1'b0;
`endif

    assign w_clr = ~en | w_resync;

    // A divisor of 0 behaves like 1: tick every clock.
    always_comb begin
        w_eff_last = '0;
        if (r_div_cur != '0) begin
            w_eff_last = r_div_cur - 1'b1;
        end
    end

    baud_div_cnt #(
        .W (CNT_W)
    ) u_os_cnt (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_clr   (w_clr),
        .i_inc   (en),
        .i_last  (w_eff_last),
        .o_wrap  (w_os_wrap)
    );

    baud_div_cnt #(
        .W (PH_W)
    ) u_ph_cnt (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_clr   (w_clr),
        .i_inc   (w_os_wrap),
        .i_last  (PH_LAST),
        .o_wrap  (w_ph_wrap)
    );

    // The divisor only changes when the oversample counter is at zero, so it never overruns.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shadow  <= DIV_RST;
            r_div_cur <= DIV_RST;
            r_tick_R  <= 1'b0;
            r_tick_T  <= 1'b0;
        end else begin
            if (div_wr) begin
                r_shadow <= div_in;
            end
            if (!en || w_resync || w_os_wrap) begin
                r_div_cur <= r_shadow;
            end
            r_tick_R <= w_os_wrap;
            r_tick_T <= w_ph_wrap;
        end
    end

    assign div_cur     = r_div_cur;
    assign baud_tick_R = r_tick_R;
    assign baud_tick_T = r_tick_T;

endmodule
